ldst_request_queue: RTL and testbench

- Requester-side load/store queue that sits between the EX/MEM pipeline register and the memory system.
- Accepts load and store operations from the pipeline and assigns each one a 4-bit queue id equal to its slot index.
- Issues requests to the memory system under its stall handshake and collects responses, which may return out of order, by id.
- Retires operations to MEM/WB strictly in program order.

---
 rtl/ldst_request_queue_if.sv | 45 ++++
 rtl/ldst_request_queue.sv | 144 ++++++++++++++
 tb/tb_ldst_request_queue.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_request_queue_if.sv
// Signal bundle between the load/store queue, the EX/MEM pipeline, the memory
// system and MEM/WB. The slave modport is the queue's view.
interface ldst_request_queue_if #(
  parameter int ID_W   = 4,
  parameter int DEST_W = 5
);
  logic              req_valid;
  logic              req_rw;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [DEST_W-1:0] req_dest;
  logic              req_ready;

  logic [31:0]       mem_addr_out;
  logic [31:0]       mem_data_out;
  logic              mem_rw_out;
  logic [ID_W-1:0]   mem_id_out;
  logic              mem_valid_out;
  logic              mem_stall_in;
  logic [31:0]       mem_data_in;
  logic [ID_W-1:0]   mem_id_in;
  logic              mem_ready_in;

  logic              wb_valid;
  logic              wb_rw;
  logic [31:0]       wb_data;
  logic [DEST_W-1:0] wb_dest;
  logic              err_out;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, req_dest,
    input  req_ready,
    input  mem_addr_out, mem_data_out, mem_rw_out, mem_id_out, mem_valid_out,
    output mem_stall_in, mem_data_in, mem_id_in, mem_ready_in,
    input  wb_valid, wb_rw, wb_data, wb_dest, err_out
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, req_dest,
    output req_ready,
    output mem_addr_out, mem_data_out, mem_rw_out, mem_id_out, mem_valid_out,
    input  mem_stall_in, mem_data_in, mem_id_in, mem_ready_in,
    output wb_valid, wb_rw, wb_data, wb_dest, err_out
  );
endinterface

// File: rtl/ldst_request_queue.sv
// Load/store request queue: in-order allocate and issue, out-of-order response
// collection by slot id, in-order retire to MEM/WB.
module ldst_request_queue #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = 4,
  parameter int DEST_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  ldst_request_queue_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ISSUED  = 2'd2,
    ST_DONE    = 2'd3
  } entry_state_e;

  localparam logic [ID_W:0] FULL_COUNT = (ID_W+1)'(DEPTH);

  entry_state_e      state_r [DEPTH];
  logic              rw_r    [DEPTH];
  logic [31:0]       addr_r  [DEPTH];
  logic [31:0]       wdata_r [DEPTH];
  logic [31:0]       rdata_r [DEPTH];
  logic [DEST_W-1:0] dest_r  [DEPTH];

  logic [ID_W-1:0]   tail_r;
  logic [ID_W-1:0]   iss_r;
  logic [ID_W-1:0]   head_r;
  logic [ID_W:0]     count_r;

  logic              ready_s;
  logic              alloc_s;
  logic              issue_s;
  logic              resp_hit_s;
  logic              resp_err_s;
  logic              retire_s;

  // The four strobes touch entries in four distinct states, so they never collide.
  always_comb begin
    ready_s    = 1'b0;
    alloc_s    = 1'b0;
    issue_s    = 1'b0;
    resp_hit_s = 1'b0;
    resp_err_s = 1'b0;
    retire_s   = 1'b0;
    ready_s    = (count_r < FULL_COUNT);
    alloc_s    = bus.req_valid && ready_s;
    issue_s    = (state_r[iss_r] == ST_PENDING) && !bus.mem_stall_in;
    retire_s   = (state_r[head_r] == ST_DONE);
    if (bus.mem_ready_in) begin
      if (state_r[bus.mem_id_in] == ST_ISSUED) begin
        resp_hit_s = 1'b1;
      end else begin
        resp_err_s = 1'b1;
      end
    end else begin
      resp_hit_s = 1'b0;
      resp_err_s = 1'b0;
    end
  end

  assign bus.req_ready     = ready_s;
  assign bus.mem_addr_out  = addr_r[iss_r];
  assign bus.mem_data_out  = wdata_r[iss_r];
  assign bus.mem_rw_out    = rw_r[iss_r];
  assign bus.mem_id_out    = iss_r;
  assign bus.mem_valid_out = (state_r[iss_r] == ST_PENDING);

  // Entry storage, entry lifecycle, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_r[i] <= ST_FREE;
        rw_r[i]    <= 1'b0;
        addr_r[i]  <= 32'd0;
        wdata_r[i] <= 32'd0;
        rdata_r[i] <= 32'd0;
        dest_r[i]  <= '0;
      end
      tail_r  <= '0;
      iss_r   <= '0;
      head_r  <= '0;
      count_r <= '0;
    end else begin
      if (alloc_s) begin
        state_r[tail_r] <= ST_PENDING;
        rw_r[tail_r]    <= bus.req_rw;
        addr_r[tail_r]  <= bus.req_addr;
        wdata_r[tail_r] <= bus.req_wdata;
        dest_r[tail_r]  <= bus.req_dest;
        rdata_r[tail_r] <= 32'd0;
        tail_r          <= tail_r + ID_W'(1);
      end
      if (issue_s) begin
        state_r[iss_r] <= ST_ISSUED;
        iss_r          <= iss_r + ID_W'(1);
      end
      // Store responses complete the entry but their data is discarded.
      if (resp_hit_s) begin
        state_r[bus.mem_id_in] <= ST_DONE;
        rdata_r[bus.mem_id_in] <= rw_r[bus.mem_id_in] ? 32'd0 : bus.mem_data_in;
      end
      if (retire_s) begin
        state_r[head_r] <= ST_FREE;
        head_r          <= head_r + ID_W'(1);
      end
      case ({alloc_s, retire_s})
        2'b10:   count_r <= count_r + (ID_W+1)'(1);
        2'b01:   count_r <= count_r - (ID_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered retire pulse; wb fields hold their last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_valid <= 1'b0;
      bus.wb_rw    <= 1'b0;
      bus.wb_data  <= 32'd0;
      bus.wb_dest  <= '0;
    end else begin
      bus.wb_valid <= retire_s;
      if (retire_s) begin
        bus.wb_rw   <= rw_r[head_r];
        bus.wb_data <= rdata_r[head_r];
        bus.wb_dest <= dest_r[head_r];
      end
    end
  end

  // Sticky flag for responses that name an entry not awaiting one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_out <= 1'b0;
    end else if (resp_err_s) begin
      bus.err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ldst_request_queue.sv
// Randomized and directed scoreboard bench for ldst_request_queue; the model is
// a program-order list of operations with issued/done flags.
module tb_ldst_request_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldst_request_queue_if #(.ID_W(4), .DEST_W(5)) bus ();

  ldst_request_queue #(.DEPTH(16), .ID_W(4), .DEST_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic [3:0]  id;
    bit          issued;
    bit          done;
    logic [31:0] data;
  } op_t;

  op_t  po[$];
  bit   model_err = 1'b0;
  int   alloc_ctr = 0;
  int   issue_log [8192];
  int   issue_cnt = 0;
  int   wb_total  = 0;
  int   checks    = 0;
  int   fails     = 0;

  int          dir_req = 0;
  int          dir_ack = 0;
  logic [3:0]  dir_id;
  logic [31:0] dir_data;
  bit          auto_resp = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor and reference model: everything sampled at the falling edge.
  always @(negedge clk) begin
    int  pidx;
    bit  found;
    op_t op;
    if (!rst_n) begin
      po.delete();
      model_err = 1'b0;
      alloc_ctr = 0;
      issue_cnt = 0;
    end else begin
      chk("err_out", 32'(bus.err_out), 32'(model_err));
      if (bus.mem_ready_in) begin
        found = 1'b0;
        foreach (po[i]) begin
          if (!found && po[i].id == bus.mem_id_in && po[i].issued && !po[i].done) begin
            po[i].done = 1'b1;
            po[i].data = po[i].rw ? 32'd0 : bus.mem_data_in;
            found = 1'b1;
          end
        end
        if (!found) model_err = 1'b1;
      end
      pidx = -1;
      foreach (po[i]) if (pidx < 0 && !po[i].issued) pidx = i;
      chk("mem_valid_out", 32'(bus.mem_valid_out), 32'(pidx >= 0));
      if (pidx >= 0 && !bus.mem_stall_in) begin
        chk("issue_addr", bus.mem_addr_out, po[pidx].addr);
        chk("issue_id", 32'(bus.mem_id_out), 32'(po[pidx].id));
        chk("issue_rw", 32'(bus.mem_rw_out), 32'(po[pidx].rw));
        if (po[pidx].rw) chk("issue_wdata", bus.mem_data_out, po[pidx].wdata);
        po[pidx].issued = 1'b1;
        issue_log[issue_cnt] = int'(po[pidx].id);
        issue_cnt++;
      end
      if (bus.wb_valid) begin
        wb_total++;
        if (po.size() == 0) begin
          chk("wb_unexpected", 32'd1, 32'd0);
        end else begin
          op = po.pop_front();
          chk("wb_in_order_done", 32'(op.done), 32'd1);
          chk("wb_rw", 32'(bus.wb_rw), 32'(op.rw));
          chk("wb_dest", 32'(bus.wb_dest), 32'(op.dest));
          chk("wb_data", bus.wb_data, op.data);
        end
      end
      chk("req_ready", 32'(bus.req_ready), 32'(po.size() < 16));
      if (bus.req_valid && bus.req_ready) begin
        op.rw = bus.req_rw; op.addr = bus.req_addr; op.wdata = bus.req_wdata;
        op.dest = bus.req_dest; op.id = 4'(alloc_ctr);
        op.issued = 1'b0; op.done = 1'b0; op.data = 32'd0;
        po.push_back(op);
        alloc_ctr++;
      end
    end
  end

  // Memory responder: directed responses first, otherwise random out-of-order ones.
  int resp_list[$];
  int rd_idx = 0;
  always @(posedge clk) begin
    int k;
    #1;
    bus.mem_ready_in = 1'b0;
    if (!rst_n) begin
      resp_list.delete();
      rd_idx = 0;
      bus.mem_id_in = 4'd0;
      bus.mem_data_in = 32'd0;
    end else begin
      while (rd_idx < issue_cnt) begin
        resp_list.push_back(issue_log[rd_idx]);
        rd_idx++;
      end
      if (dir_ack != dir_req) begin
        bus.mem_ready_in = 1'b1;
        bus.mem_id_in = dir_id;
        bus.mem_data_in = dir_data;
        for (int j = resp_list.size() - 1; j >= 0; j--)
          if (resp_list[j] == int'(dir_id)) resp_list.delete(j);
        dir_ack++;
      end else if (auto_resp && resp_list.size() > 0 && $urandom_range(2) == 0) begin
        k = $urandom_range(resp_list.size() - 1);
        bus.mem_ready_in = 1'b1;
        bus.mem_id_in = 4'(resp_list[k]);
        bus.mem_data_in = $urandom;
        resp_list.delete(k);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic alloc(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] dst);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = a;
    bus.req_wdata = d; bus.req_dest = dst;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) chk("alloc_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic respond(input logic [3:0] id, input logic [31:0] d);
    int n = 0;
    dir_id = id; dir_data = d; dir_req++;
    while (dir_ack != dir_req && n < 10) begin n++; idle(1); end
    if (n >= 10) chk("respond_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_issues(input int target);
    int n = 0;
    while (issue_cnt < target && n < 100) begin n++; idle(1); end
    chk("issue_wait", 32'(issue_cnt >= target), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = 1'b0; bus.mem_stall_in = 1'b0; auto_resp = 1'b1;
    while (po.size() > 0 && n < 3000) begin n++; idle(1); end
    chk("drain_empty", 32'(po.size()), 32'd0);
    auto_resp = 1'b0;
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int wb0;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.req_dest = 5'd0; bus.mem_stall_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_valid", 32'(bus.mem_valid_out), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_err", 32'(bus.err_out), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Single load, response two cycles after issue.
    wb0 = wb_total;
    alloc(1'b0, 32'h40, 32'd0, 5'd3);
    wait_issues(1);
    idle(2);
    respond(4'd0, 32'hDEADBEEF);
    drain();
    chk("t1_wb_pulses", 32'(wb_total - wb0), 32'd1);

    // Out-of-order responses retire in program order.
    do_reset();
    wb0 = wb_total;
    alloc(1'b0, 32'h100, 32'd0, 5'd1);
    alloc(1'b0, 32'h104, 32'd0, 5'd2);
    wait_issues(2);
    respond(4'd1, 32'h11);
    idle(4);
    chk("t2_no_early_retire", 32'(wb_total - wb0), 32'd0);
    respond(4'd0, 32'h22);
    drain();
    chk("t2_wb_pulses", 32'(wb_total - wb0), 32'd2);

    // Stall holds the presented request; release issues back to back.
    do_reset();
    bus.mem_stall_in = 1'b1;
    alloc(1'b1, 32'h200, 32'hA0, 5'd4);
    alloc(1'b0, 32'h204, 32'd0, 5'd5);
    alloc(1'b1, 32'h208, 32'hA2, 5'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_stall_addr", bus.mem_addr_out, 32'h200);
      chk("t3_stall_id", 32'(bus.mem_id_out), 32'd0);
      @(posedge clk); #1;
    end
    bus.mem_stall_in = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      idle(1);
      chk("t3_issue_seq", 32'(issue_cnt), 32'(c));
    end
    drain();

    // Full queue, retire of id 0, then wrap-around allocation.
    do_reset();
    for (int c = 0; c < 16; c++) alloc(1'b0, 32'h1000 + 32'(c * 4), 32'd0, 5'(c));
    idle(2);
    chk("t4_full_not_ready", 32'(bus.req_ready), 32'd0);
    wb0 = wb_total;
    respond(4'd0, 32'h55AA55AA);
    for (int n = 0; n < 10 && wb_total == wb0; n++) idle(1);
    chk("t4_retired", 32'(wb_total - wb0), 32'd1);
    chk("t4_ready_again", 32'(bus.req_ready), 32'd1);
    alloc(1'b1, 32'h2000, 32'h77, 5'd9);
    chk("t4_wrap_valid", 32'(bus.mem_valid_out), 32'd1);
    chk("t4_wrap_id", 32'(bus.mem_id_out), 32'd0);
    drain();

    // Stray response sets a sticky error; reset mid-flight clears everything.
    do_reset();
    wb0 = wb_total;
    respond(4'd5, 32'h12345678);
    idle(2);
    chk("t5_err_set", 32'(bus.err_out), 32'd1);
    idle(5);
    chk("t5_err_sticky", 32'(bus.err_out), 32'd1);
    chk("t5_no_wb", 32'(wb_total - wb0), 32'd0);
    bus.mem_stall_in = 1'b1;
    for (int c = 0; c < 4; c++) alloc(1'b0, 32'h300 + 32'(c * 4), 32'd0, 5'(c));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_valid", 32'(bus.mem_valid_out), 32'd0);
    chk("t5_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("t5_rst_err", 32'(bus.err_out), 32'd0);
    chk("t5_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("t5_rst_wb_dest", 32'(bus.wb_dest), 32'd0);
    bus.mem_stall_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Random traffic with random stalls and out-of-order responses.
    auto_resp = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.mem_stall_in = ($urandom_range(3) == 0);
      bus.req_valid = ($urandom_range(1) == 1);
      bus.req_rw = 1'($urandom_range(1));
      bus.req_addr = $urandom;
      bus.req_wdata = $urandom;
      bus.req_dest = 5'($urandom_range(31));
      idle(1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
